// File: rtl/msk_state_unloader.sv
// ---------------------------------------------------------------------------
// msk_state_unloader
//
// Captures the full 128-bit masked AES state (d shares per bit) in one cycle
// and streams it to a downstream share consumer as four 32-bit column beats
// (32*d bits each, share-interleaved per byte) over a valid/ready handshake.
// Share bits are only moved or zeroed, never combined with each other.
//
// Optional build macro: SMAESH_UNLOADER_ZEROIZE_EN
//   defined   : rst also clears the share buffer, and sh_data_out is forced
//               to 0 whenever out_valid is low.
//   undefined : the share buffer has no reset, and sh_data_out is
//               unconstrained while out_valid is low. Control is identical.
//
// Ports
//   clk          in   1       clock, rising edge
//   rst          in   1       synchronous, active-high reset
//   in_valid     in   1       sh_data_in holds a complete shared state
//   in_ready     out  1       unloader can accept a state (high in IDLE)
//   sh_data_in   in   128*d   byte i at [8*d*i +: 8*d], share s of that byte
//                             at [8*d*i + 8*s +: 8]
//   out_valid    out  1       sh_data_out holds a valid column beat
//   out_ready    in   1       consumer accepts the beat
//   sh_data_out  out  32*d    beat k = bytes 4k..4k+3, same per-byte layout
//   out_last     out  1       high with out_valid on beat 3
//   busy         out  1       high while streaming (SEND)
// ---------------------------------------------------------------------------
module msk_state_unloader #(
  parameter int d = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [128*d-1:0]  sh_data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*d-1:0]   sh_data_out,
  output logic              out_last,
  output logic              busy
);

  localparam int BW = 32 * d;   // one column beat
  localparam int SW = 128 * d;  // whole shared state

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [SW-1:0]   shift_q, shift_d;
  logic            shift_en;
  logic            in_ready_q, out_valid_q, out_last_q, busy_q;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_en = 1'b0;
    shift_d  = shift_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d  = SEND;
          cnt_d    = 2'd0;
          shift_en = 1'b1;
          shift_d  = sh_data_in;
        end
      end
      SEND: begin
        if (out_ready) begin
          // Fixed right shift by one column; residual shares are replaced by
          // zeros so the buffer is empty once the last beat is accepted.
          shift_en = 1'b1;
          shift_d  = {{BW{1'b0}}, shift_q[SW-1:BW]};
          cnt_d    = cnt_q + 2'd1;  // wraps to 0 after beat 3
          if (cnt_q == 2'd3) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control FSM with registered handshake outputs; in_ready never depends
  // combinationally on out_ready.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == SEND);
      out_last_q  <= (state_d == SEND) && (cnt_d == 2'd3);
      busy_q      <= (state_d == SEND);
    end
  end

`ifdef SMAESH_UNLOADER_ZEROIZE_EN
  always_ff @(posedge clk) begin
    if (rst)           shift_q <= '0;
    else if (shift_en) shift_q <= shift_d;
  end

  // AND-gate the output so no share data is visible outside a valid beat.
  assign sh_data_out = shift_q[BW-1:0] & {BW{out_valid_q}};
`else
  // NOTE: the share buffer is deliberately left without reset, like the
  // other share registers; control alone decides whether its content is used.
  always_ff @(posedge clk) begin
    if (shift_en) shift_q <= shift_d;
  end

  assign sh_data_out = shift_q[BW-1:0];
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule
